// File: rtl/fir_coeff_loader_if.sv
// rtl/fir_coeff_loader_if.sv - host coefficient write stream between host and loader
//
// Purpose: carries one coefficient word per accepted handshake (wr_valid & wr_ready).
// Signals:
//   wr_valid  host -> loader  word on wr_data is valid
//   wr_data   host -> loader  coefficient word, CW bits, tap 0 first
//   wr_ready  loader -> host  loader can take wr_data this cycle
interface fir_coeff_loader_if #(
  parameter int CW = 17
);
  logic          wr_valid;
  logic [CW-1:0] wr_data;
  logic          wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - shadow/active coefficient bank loader for the FIR_4_tap cascade
//
// Purpose: collects NTAPS coefficient words into a shadow bank, then copies the whole
// bank into the active bank on one sample-enable edge so no sample sees a mixed set.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_sample_en     sample strobe shared with the FIR stages; gates the commit
//   i_load_start    pulse: begin (or restart) a load
//   i_load_abort    pulse: drop the load in progress
//   i_err_clr       clears the sticky error flag
//   wr              coefficient write stream (slave side)
//   o_coeff_flat    active bank, tap k at [k*CW +: CW]
//   o_busy          loading or waiting for commit
//   o_done          one-cycle pulse after the commit edge
//   o_err           sticky: restart during a load, or a write while idle
module fir_coeff_loader #(
  parameter int            NTAPS       = 16,
  parameter int            CW          = 17,
  parameter logic [CW-1:0] RESET_COEFF = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_sample_en,
  input  logic                  i_load_start,
  input  logic                  i_load_abort,
  input  logic                  i_err_clr,
  fir_coeff_loader_if.slave     wr,
  output logic [NTAPS*CW-1:0]   o_coeff_flat,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int            IW       = $clog2(NTAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_shadow [NTAPS];
  logic [NTAPS*CW-1:0]   r_active;
  logic                  r_wr_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_active_load;
  logic                  w_err_set;

  assign w_active_load = (r_state == S_LOAD) || (r_state == S_PEND);

  // A stray write while idle, or a restart that is not overridden by abort.
  assign w_err_set = ((r_state == S_IDLE) && wr.wr_valid) ||
                     (w_active_load && !i_load_abort && i_load_start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_shadow[k]             <= RESET_COEFF;
        r_active[k*CW +: CW]    <= RESET_COEFF;
      end
    end else begin
      r_done <= 1'b0;
      // Set has priority over clear.
      r_err  <= w_err_set | (r_err & ~i_err_clr);

      case (r_state)
        S_IDLE: begin
          if (i_load_start) begin
            r_state    <= S_LOAD;
            r_idx      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_LOAD, S_PEND: begin
          if (i_load_abort) begin
            // Also drops any word offered on this edge, including the final one.
            r_state    <= S_IDLE;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (i_load_start) begin
            r_state    <= S_LOAD;
            r_idx      <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b1;
          end else if ((r_state == S_LOAD) && wr.wr_valid) begin
            r_shadow[r_idx] <= wr.wr_data;
            if (r_idx == LAST_IDX) begin
              r_state    <= S_PEND;
              r_wr_ready <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if ((r_state == S_PEND) && i_sample_en) begin
            // The sample taken on this edge still sees the old bank.
            for (int k = 0; k < NTAPS; k++) begin
              r_active[k*CW +: CW] <= r_shadow[k];
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_wr_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_ready  = r_wr_ready;
  assign o_coeff_flat = r_active;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
